// File: rtl/seg_scan_mux.sv
// Purpose : time-multiplexed 8-digit 7-segment scanner with frame-coherent latching and anti-ghost blanking.
// Latency : cat/seg are registered and lag the internal scan state by one cycle; inputs are sampled once per frame.
// Backpres: none; free-running scan that cannot stall, and data/enable are sampled only at frame boundaries.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   data       packed hex nibbles, digit k = data[4k+3:4k], digit 7 leftmost
//   enable     per-digit show mask, enable[k]=0 blanks digit k
//   cat        active-low cathode selects, cat[k] drives digit k, idle 8'hFF
//   seg        {dp,g,f,e,d,c,b,a} active-high, dp always 0
//   frame_tick one-cycle pulse on the cycle after the shadow registers load
module seg_scan_mux #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data,
   input  logic [7:0]  enable,
   output logic [7:0]  cat,
   output logic [7:0]  seg,
   output logic        frame_tick
);

   generate
      if (SCAN_DIV < 2 || BLANK_CYC < 1 || BLANK_CYC > SCAN_DIV - 1) begin : g_bad_param
         $error("seg_scan_mux: need SCAN_DIV >= 2 and 1 <= BLANK_CYC <= SCAN_DIV-1");
      end
   endgenerate

   localparam int             CW        = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   data_sh_q, data_sh_d;
   logic [7:0]    en_sh_q, en_sh_d;
   logic [7:0]    cat_q, cat_d;
   logic [7:0]    seg_q, seg_d;
   logic          frame_tick_q, frame_tick_d;
   logic          slot_end;
   logic          frame_end;
   logic [3:0]    nib;

   // Hex font, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] font(input logic [3:0] v);
      logic [6:0] f;
      case (v)
         4'h0: f = 7'h3F;
         4'h1: f = 7'h06;
         4'h2: f = 7'h5B;
         4'h3: f = 7'h4F;
         4'h4: f = 7'h66;
         4'h5: f = 7'h6D;
         4'h6: f = 7'h7D;
         4'h7: f = 7'h07;
         4'h8: f = 7'h7F;
         4'h9: f = 7'h6F;
         4'hA: f = 7'h77;
         4'hB: f = 7'h7C;
         4'hC: f = 7'h39;
         4'hD: f = 7'h5E;
         4'hE: f = 7'h79;
         default: f = 7'h71;
      endcase
      return f;
   endfunction

   always_comb begin
      slot_end     = (cnt_q == CNT_LAST);
      frame_end    = slot_end && (idx_q == 3'd7);
      cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
      idx_d        = slot_end ? idx_q + 3'd1 : idx_q;
      // Shadow load only at the frame boundary so a frame never mixes old and new digits.
      data_sh_d    = frame_end ? data   : data_sh_q;
      en_sh_d      = frame_end ? enable : en_sh_q;
      frame_tick_d = frame_end;
      nib          = data_sh_q[4*idx_q +: 4];
      // Blank the head of every slot so the previous digit's pattern never ghosts onto the next cathode.
      if (cnt_q < BLANK_END || !en_sh_q[idx_q]) begin
         cat_d = 8'hFF;
         seg_d = 8'h00;
      end else begin
         cat_d = ~(8'b1 << idx_q);
         seg_d = {1'b0, font(nib)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         data_sh_q    <= 32'h0;
         en_sh_q      <= 8'h00;
         cat_q        <= 8'hFF;
         seg_q        <= 8'h00;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         data_sh_q    <= data_sh_d;
         en_sh_q      <= en_sh_d;
         cat_q        <= cat_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign cat        = cat_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule
